// File: rtl/imem_encoder.sv
// imem_encoder: packs R/I/J instruction fields into 32-bit words and writes them
// to consecutive instruction-memory addresses, keeping an XOR checksum. Rev 1.0
`default_nettype none

module imem_encoder #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_abort,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_fmt,
  input  logic [5:0]        i_op,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [5:0]        i_func,
  input  logic [15:0]       i_imm16,
  input  logic [25:0]       i_target,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr_ptr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_err;
  logic [31:0]       r_checksum;

  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_legal;
  logic              w_illegal;
  logic              w_start;

  always_comb begin
    w_word = '0;
    case (i_fmt)
      2'd0:    w_word = {i_op, i_rs, i_rt, i_rd, i_shamt, i_func};
      2'd1:    w_word = {i_op, i_rs, i_rt, i_imm16};
      2'd2:    w_word = {i_op, i_target};
      default: w_word = '0;
    endcase
  end

  // An accept coinciding with abort is discarded entirely, including err.
  assign w_accept  = (r_state == S_LOAD) && i_in_valid && !i_abort;
  assign w_legal   = w_accept && (i_fmt != 2'd3);
  assign w_illegal = w_accept && (i_fmt == 2'd3);
  assign w_start   = (r_state == S_IDLE) && i_start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_legal && (r_remaining == CNT_W'(1))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_ptr  <= '0;
      r_remaining <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_mem_we <= w_legal;
      if (w_start) begin
        r_addr_ptr  <= i_base_addr;
        r_remaining <= i_count;
        r_checksum  <= '0;
        r_err       <= 1'b0;
      end
      if (w_legal) begin
        r_mem_addr  <= r_addr_ptr;
        r_mem_wdata <= w_word;
        r_addr_ptr  <= r_addr_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
        r_checksum  <= r_checksum ^ w_word;
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_busy      = (r_state == S_LOAD);
  assign o_in_ready  = o_busy;
  assign o_done      = (r_state == S_DONE);
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_err       = r_err;
  assign o_checksum  = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_imem_encoder.sv
// tb_imem_encoder: directed scenarios plus randomized loads checked against a
// transaction-level model of the encoder/loader.
`default_nettype none

module tb_imem_encoder;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 10;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start, i_abort, i_in_valid;
  logic [ADDR_W-1:0] i_base_addr;
  logic [CNT_W-1:0]  i_count;
  logic [1:0]        i_fmt;
  logic [5:0]        i_op, i_func;
  logic [4:0]        i_rs, i_rt, i_rd, i_shamt;
  logic [15:0]       i_imm16;
  logic [25:0]       i_target;
  logic              o_in_ready, o_mem_we, o_busy, o_done, o_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata, o_checksum;

  int n_vec  = 0;
  int n_miss = 0;

  int          m_phase;
  int unsigned m_ptr, m_rem, m_csum, m_waddr, m_wdata;
  bit          m_err, m_we;

  imem_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_count     (i_count),
    .i_abort     (i_abort),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_fmt       (i_fmt),
    .i_op        (i_op),
    .i_rs        (i_rs),
    .i_rt        (i_rt),
    .i_rd        (i_rd),
    .i_shamt     (i_shamt),
    .i_func      (i_func),
    .i_imm16     (i_imm16),
    .i_target    (i_target),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_checksum  (o_checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Field packing by weighted sums of the MIPS bit positions.
  function automatic int unsigned ref_enc(int unsigned f);
    int unsigned op = i_op, rs = i_rs, rt = i_rt, rd = i_rd;
    int unsigned sh = i_shamt, fn = i_func, imm = i_imm16, tg = i_target;
    case (f)
      0: return op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
      1: return op * 67108864 + rs * 2097152 + rt * 65536 + imm;
      2: return op * 67108864 + tg;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_ptr = 0; m_rem = 0; m_csum = 0;
    m_err = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".we"},    {31'd0, o_mem_we},   {31'd0, m_we});
    chk({tag, ".addr"},  32'(o_mem_addr),     m_waddr);
    chk({tag, ".wdata"}, o_mem_wdata,         m_wdata);
    chk({tag, ".done"},  {31'd0, o_done},     {31'd0, m_phase == M_DONE});
    chk({tag, ".busy"},  {31'd0, o_busy},     {31'd0, m_phase == M_LOAD});
    chk({tag, ".rdy"},   {31'd0, o_in_ready}, {31'd0, m_phase == M_LOAD});
    chk({tag, ".err"},   {31'd0, o_err},      {31'd0, m_err});
    chk({tag, ".csum"},  o_checksum,          m_csum);
  endtask

  // Advance the model by one clock using the inputs currently driven, then compare.
  task automatic cycle(input string tag);
    int unsigned w;
    m_we = 0;
    case (m_phase)
      M_IDLE: if (i_start) begin
        m_ptr = i_base_addr; m_rem = i_count; m_csum = 0; m_err = 0;
        m_phase = (i_count == 0) ? M_DONE : M_LOAD;
      end
      M_LOAD: begin
        if (i_abort) m_phase = M_IDLE;
        else if (i_in_valid) begin
          if (i_fmt == 2'd3) m_err = 1;
          else begin
            w = ref_enc(i_fmt);
            m_we = 1; m_waddr = m_ptr; m_wdata = w;
            m_ptr = (m_ptr + 1) % (1 << ADDR_W);
            m_rem = m_rem - 1;
            m_csum = m_csum ^ w;
            if (m_rem == 0) m_phase = M_DONE;
          end
        end
      end
      default: m_phase = M_IDLE;
    endcase
    @(posedge clk); #1;
    check_outs(tag);
  endtask

  task automatic load_start(input int base, input int cnt);
    i_start = 1; i_base_addr = ADDR_W'(base); i_count = CNT_W'(cnt);
    cycle("start");
    i_start = 0;
  endtask

  task automatic send(input int f, input int op, input int rs, input int rt, input int rd,
                      input int sh, input int fn, input int imm, input int tg);
    i_fmt = 2'(f); i_op = 6'(op); i_rs = 5'(rs); i_rt = 5'(rt); i_rd = 5'(rd);
    i_shamt = 5'(sh); i_func = 6'(fn); i_imm16 = 16'(imm); i_target = 26'(tg);
    i_in_valid = 1;
    cycle("send");
    i_in_valid = 0;
  endtask

  task automatic async_reset();
    rst_n = 0; #1;
    model_reset();
    check_outs("rst_async");
    @(posedge clk); #1;
    check_outs("rst_hold");
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; i_start = 0; i_abort = 0; i_in_valid = 0; i_base_addr = '0; i_count = '0;
    i_fmt = '0; i_op = '0; i_rs = '0; i_rt = '0; i_rd = '0; i_shamt = '0; i_func = '0;
    i_imm16 = '0; i_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    rst_n = 1;
    cycle("idle");

    // Single R-format word.
    load_start(12'h010, 1);
    send(0, 0, 1, 2, 3, 0, 6'h20, 0, 0);
    chk("r_wdata", o_mem_wdata, 32'h00221820);
    chk("r_addr",  32'(o_mem_addr), 32'h010);
    chk("r_done",  {31'd0, o_done}, 32'd1);
    cycle("idle");

    // Back-to-back R, I, J burst.
    load_start(12'h080, 3);
    send(0, 0, 1, 2, 3, 0, 6'h20, 0, 0);
    send(1, 6'h08, 1, 2, 0, 0, 0, 16'h0005, 0);
    chk("i_wdata", o_mem_wdata, 32'h20220005);
    send(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h0100000);
    chk("j_wdata", o_mem_wdata, 32'h08100000);
    chk("j_addr",  32'(o_mem_addr), 32'h082);
    chk("burst_done", {31'd0, o_done}, 32'd1);
    chk("burst_csum", o_checksum, 32'h28101825);
    cycle("idle");

    // Address wrap with a gap in in_valid.
    load_start(12'h3FF, 2);
    send(1, 1, 2, 3, 0, 0, 0, 16'h1234, 0);
    chk("wrap_a0", 32'(o_mem_addr), 32'h3FF);
    repeat (3) begin
      cycle("gap");
      chk("gap_busy", {31'd0, o_busy}, 32'd1);
    end
    send(2, 3, 0, 0, 0, 0, 0, 0, 26'h3ABCDEF);
    chk("wrap_a1", 32'(o_mem_addr), 32'h000);
    chk("wrap_done", {31'd0, o_done}, 32'd1);
    cycle("idle");

    // Illegal format followed by a legal word.
    load_start(12'h020, 1);
    send(3, 6'h3F, 1, 1, 1, 1, 1, 1, 1);
    chk("ill_we",  {31'd0, o_mem_we}, 32'd0);
    chk("ill_err", {31'd0, o_err}, 32'd1);
    send(1, 6'h08, 1, 2, 0, 0, 0, 16'h0005, 0);
    chk("ill_addr", 32'(o_mem_addr), 32'h020);
    cycle("idle");
    chk("ill_sticky", {31'd0, o_err}, 32'd1);

    // Abort alongside the second accept, then reset mid-load.
    load_start(12'h100, 4);
    send(0, 1, 2, 3, 4, 5, 6, 0, 0);
    i_abort = 1;
    send(0, 7, 7, 7, 7, 7, 7, 0, 0);
    i_abort = 0;
    chk("abort_we",   {31'd0, o_mem_we}, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    cycle("idle");
    load_start(12'h200, 3);
    send(0, 1, 2, 3, 4, 5, 6, 0, 0);
    async_reset();
    cycle("idle");

    // count=0 and start while busy.
    load_start(12'h055, 0);
    chk("zero_done", {31'd0, o_done}, 32'd1);
    cycle("idle");
    load_start(12'h040, 2);
    send(0, 1, 1, 1, 1, 1, 1, 0, 0);
    i_start = 1; i_base_addr = 10'h200; i_count = 10'd5;
    cycle("restart");
    i_start = 0;
    send(2, 2, 0, 0, 0, 0, 0, 0, 26'h155);
    chk("restart_addr", 32'(o_mem_addr), 32'h041);
    chk("restart_done", {31'd0, o_done}, 32'd1);
    cycle("idle");

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      i_start     = ($urandom % 8) == 0;
      i_base_addr = ADDR_W'($urandom);
      i_count     = CNT_W'($urandom % 6);
      i_abort     = ($urandom % 24) == 0;
      i_in_valid  = ($urandom % 3) != 0;
      i_fmt       = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
      i_op = 6'($urandom); i_rs = 5'($urandom); i_rt = 5'($urandom); i_rd = 5'($urandom);
      i_shamt = 5'($urandom); i_func = 6'($urandom); i_imm16 = 16'($urandom);
      i_target = 26'($urandom);
      if (($urandom % 400) == 0) async_reset();
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
